// File: rtl/maze_pkg.sv
// Shared encodings and grid defaults for the maze move sequencer.
package maze_pkg;

  typedef enum logic [2:0] {
    MV_STOP    = 3'd0,
    MV_FORWARD = 3'd1,
    MV_LEFT    = 3'd2,
    MV_RIGHT   = 3'd3,
    MV_U_TURN  = 3'd4
  } move_e;

  typedef enum logic [1:0] {
    HD_N = 2'd0,
    HD_E = 2'd1,
    HD_S = 2'd2,
    HD_W = 2'd3
  } heading_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } state_e;

  localparam int unsigned MAZE_ROWS    = 9;
  localparam int unsigned MAZE_COLS    = 9;
  localparam int unsigned MAZE_START_R = 4;
  localparam int unsigned MAZE_START_C = 0;
  localparam int unsigned MAZE_EXIT_R  = 4;
  localparam int unsigned MAZE_EXIT_C  = 8;

  // Heading after the rotation part of a move; FORWARD keeps the heading.
  function automatic heading_e rotate(input heading_e h, input logic [2:0] code);
    logic [1:0] delta;
    case (code)
      MV_LEFT:   delta = 2'd3;
      MV_RIGHT:  delta = 2'd1;
      MV_U_TURN: delta = 2'd2;
      default:   delta = 2'd0;
    endcase
    return heading_e'(h + delta);
  endfunction

endpackage

// File: rtl/maze_cmd_fifo.sv
// Synchronous show-ahead FIFO buffering explorer move commands.
module maze_cmd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             push_en;
  logic             pop_en;

  assign push_en = push && !full;
  assign pop_en  = pop && !empty;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop_en)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/maze_move_sequencer.sv
// Issues buffered explorer moves to the motion executor and tracks bot pose.
// Optional executor watchdog enabled by defining WATCHDOG_EN.
module maze_move_sequencer
  import maze_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned ROWS           = MAZE_ROWS,
  parameter int unsigned COLS           = MAZE_COLS,
  parameter int unsigned START_R        = MAZE_START_R,
  parameter int unsigned START_C        = MAZE_START_C,
  parameter int unsigned EXIT_R         = MAZE_EXIT_R,
  parameter int unsigned EXIT_C         = MAZE_EXIT_C,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  input  logic [2:0] cmd,
  output logic       cmd_ready,
  output logic       exec_start,
  output logic [2:0] exec_cmd,
  input  logic       exec_done,
  output logic [3:0] pos_row,
  output logic [3:0] pos_col,
  output logic [1:0] heading,
  output logic [3:0] deadend_cnt,
  output logic       at_exit,
  output logic       busy,
  output logic       err
);

  localparam logic signed [4:0] ROWS_S   = 5'(ROWS);
  localparam logic signed [4:0] COLS_S   = 5'(COLS);
  localparam logic [3:0]        START_R4 = 4'(START_R);
  localparam logic [3:0]        START_C4 = 4'(START_C);
  localparam logic [3:0]        EXIT_R4  = 4'(EXIT_R);
  localparam logic [3:0]        EXIT_C4  = 4'(EXIT_C);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("maze_move_sequencer: FIFO_DEPTH must be a power of two >= 2, TIMEOUT_CYCLES >= 1");
  end

  state_e     state;
  heading_e   hd_q;
  logic [3:0] row_q;
  logic [3:0] col_q;
  logic [3:0] dead_q;

  logic       fifo_full;
  logic       fifo_empty;
  logic [2:0] head;
  logic       push;
  logic       pop;

  assign cmd_ready = !fifo_full && (state != ST_DONE);
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state == ST_IDLE) && !fifo_empty;
  assign busy      = !fifo_empty || (state != ST_IDLE);

  maze_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (3)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (cmd),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Candidate pose for the move being executed; signed 5-bit catches -1 and overflow.
  heading_e          new_hd;
  logic signed [4:0] nr;
  logic signed [4:0] nc;
  logic              in_bounds;
  logic              hits_exit;

  always_comb begin
    new_hd = rotate(hd_q, exec_cmd);
    nr     = $signed({1'b0, row_q});
    nc     = $signed({1'b0, col_q});
    case (new_hd)
      HD_N:    nr = nr - 5'sd1;
      HD_E:    nc = nc + 5'sd1;
      HD_S:    nr = nr + 5'sd1;
      default: nc = nc - 5'sd1;
    endcase
    in_bounds = (nr >= 5'sd0) && (nr < ROWS_S) && (nc >= 5'sd0) && (nc < COLS_S);
    hits_exit = in_bounds && (nr[3:0] == EXIT_R4) && (nc[3:0] == EXIT_C4);
  end

`ifdef WATCHDOG_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      row_q      <= START_R4;
      col_q      <= START_C4;
      hd_q       <= HD_E;
      dead_q     <= '0;
      at_exit    <= 1'b0;
      err        <= 1'b0;
      exec_start <= 1'b0;
      exec_cmd   <= '0;
`ifdef WATCHDOG_EN
      wd_q       <= '0;
`endif
    end else begin
      exec_start <= 1'b0;
      if (exec_done && state != ST_WAIT) err <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            case (head)
              MV_STOP: state <= ST_DONE;
              MV_FORWARD, MV_LEFT, MV_RIGHT, MV_U_TURN: begin
                exec_cmd   <= head;
                exec_start <= 1'b1;
                state      <= ST_ISSUE;
              end
              default: err <= 1'b1;
            endcase
          end
        end

        ST_ISSUE: begin
          state <= ST_WAIT;
`ifdef WATCHDOG_EN
          wd_q  <= '0;
`endif
        end

        ST_WAIT: begin
          if (exec_done) begin
            hd_q <= new_hd;
            if (exec_cmd == MV_U_TURN && dead_q != 4'hF) dead_q <= dead_q + 4'd1;
            // Off-grid moves still turn the bot but leave the cell unchanged.
            if (in_bounds) begin
              row_q <= nr[3:0];
              col_q <= nc[3:0];
            end else begin
              err <= 1'b1;
            end
            if (hits_exit) begin
              at_exit <= 1'b1;
              state   <= ST_DONE;
            end else begin
              state   <= ST_IDLE;
            end
          end
`ifdef WATCHDOG_EN
          else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
            err   <= 1'b1;
            state <= ST_DONE;
          end else begin
            wd_q  <= wd_q + WD_W'(1);
          end
`endif
        end

        default: state <= ST_DONE;
      endcase
    end
  end

  assign pos_row     = row_q;
  assign pos_col     = col_q;
  assign heading     = hd_q;
  assign deadend_cnt = dead_q;

endmodule

// File: tb/tb_maze_move_sequencer.sv
// Directed and randomized checks of maze_move_sequencer against a pose model.
module tb_maze_move_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [2:0] cmd = 3'd0;
  logic       cmd_ready;
  logic       exec_start;
  logic [2:0] exec_cmd;
  logic       exec_done = 1'b0;
  logic [3:0] pos_row;
  logic [3:0] pos_col;
  logic [1:0] heading;
  logic [3:0] deadend_cnt;
  logic       at_exit;
  logic       busy;
  logic       err;

  int checks = 0;
  int errors = 0;

  // Reference model: pose on a 9x9 grid, start (4,0) facing E, exit (4,8).
  int m_row, m_col, m_hd, m_dead;
  bit m_err, m_done, m_exit;
  int dr[4] = '{-1, 0, 1, 0};
  int dc[4] = '{0, 1, 0, -1};

  always #5 clk = ~clk;

  maze_move_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd         (cmd),
    .cmd_ready   (cmd_ready),
    .exec_start  (exec_start),
    .exec_cmd    (exec_cmd),
    .exec_done   (exec_done),
    .pos_row     (pos_row),
    .pos_col     (pos_col),
    .heading     (heading),
    .deadend_cnt (deadend_cnt),
    .at_exit     (at_exit),
    .busy        (busy),
    .err         (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_row = 4; m_col = 0; m_hd = 1; m_dead = 0;
    m_err = 0; m_done = 0; m_exit = 0;
  endtask

  task automatic model_move(input int c);
    int turn, r, cc;
    turn = (c == 2) ? 3 : (c == 3) ? 1 : (c == 4) ? 2 : 0;
    m_hd = (m_hd + turn) % 4;
    if (c == 4 && m_dead < 15) m_dead++;
    r  = m_row + dr[m_hd];
    cc = m_col + dc[m_hd];
    if (r < 0 || r > 8 || cc < 0 || cc > 8) m_err = 1;
    else begin
      m_row = r; m_col = cc;
      if (r == 4 && cc == 8) begin m_exit = 1; m_done = 1; end
    end
  endtask

  task automatic compare_all(input string tag);
    chk({tag, ".row"},  pos_row,     m_row);
    chk({tag, ".col"},  pos_col,     m_col);
    chk({tag, ".hd"},   heading,     m_hd);
    chk({tag, ".dead"}, deadend_cnt, m_dead);
    chk({tag, ".exit"}, at_exit,     m_exit);
    chk({tag, ".err"},  err,         m_err);
    chk({tag, ".rdy"},  cmd_ready,   !m_done);
    chk({tag, ".busy"}, busy,        m_done);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; cmd_valid = 1'b0; exec_done = 1'b0;
    @(posedge clk); @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
  endtask

  task automatic pulse_done();
    exec_done = 1'b1;
    @(posedge clk);
    #1 exec_done = 1'b0;
  endtask

  // Push one command into an empty, idle sequencer and play executor for it.
  task automatic do_move(input int c);
    bit acc;
    int n;
    int d;
    @(negedge clk);
    cmd_valid = 1'b1; cmd = 3'(c); acc = cmd_ready;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    chk("accept", acc, !m_done);
    if (!acc) return;
    if (c == 0 || c > 4) begin
      if (c == 0) m_done = 1; else m_err = 1;
      n = 0;
      repeat (3) begin @(negedge clk); if (exec_start) n++; end
      chk("no_start", n, 0);
      compare_all("nomove");
      return;
    end
    n = 0;
    do begin @(negedge clk); n++; end while (!exec_start && n < 10);
    chk("start_lat", n, 2);
    chk("exec_cmd", exec_cmd, c);
    d = $urandom_range(0, 3);
    @(negedge clk);
    chk("start_pulse", exec_start, 0);
    repeat (d) @(negedge clk);
    chk("cmd_hold", exec_cmd, c);
    pulse_done();
    model_move(c);
    @(negedge clk);
    compare_all("move");
  endtask

  initial begin
    int acc_cnt, n, c;
    logic [2:0] seq6 [6];

    // Reset values and single FORWARD with exact latency
    do_reset();
    @(negedge clk);
    compare_all("reset");
    chk("reset.exec_start", exec_start, 0);
    chk("reset.exec_cmd", exec_cmd, 0);
    cmd_valid = 1'b1; cmd = 3'd1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk); chk("lat.n1", exec_start, 0);
    @(negedge clk); chk("lat.n2", exec_start, 1); chk("lat.cmd", exec_cmd, 1);
    @(negedge clk); chk("lat.n3", exec_start, 0);
    pulse_done();
    @(negedge clk);
    chk("fwd.row", pos_row, 4); chk("fwd.col", pos_col, 1);
    chk("fwd.hd", heading, 1);  chk("fwd.busy", busy, 0);

    // Eight FORWARDs reach the exit; the ninth is refused
    do_reset();
    for (int i = 0; i < 8; i++) do_move(1);
    chk("exit.col", pos_col, 8); chk("exit.flag", at_exit, 1); chk("exit.rdy", cmd_ready, 0);
    do_move(1);
    n = 0;
    repeat (5) begin @(negedge clk); if (exec_start) n++; end
    chk("exit.no_start", n, 0);

    // LEFT then U_TURN
    do_reset();
    do_move(2);
    chk("left.hd", heading, 0); chk("left.row", pos_row, 3);
    do_move(4);
    chk("ut.hd", heading, 2); chk("ut.row", pos_row, 4); chk("ut.dead", deadend_cnt, 1);

    // U_TURN off the west edge
    do_reset();
    do_move(4);
    chk("oob.err", err, 1); chk("oob.col", pos_col, 0); chk("oob.hd", heading, 3);
    chk("oob.busy", busy, 0);

    // STOP parks the sequencer; invalid codes flag err
    do_reset();
    do_move(6);
    chk("bad.err", err, 1);
    do_move(3);
    do_move(0);
    chk("stop.rdy", cmd_ready, 0);

    // Dead-end counter saturation
    do_reset();
    for (int i = 0; i < 17; i++) do_move(4);
    chk("sat.dead", deadend_cnt, 15);

    // Backpressure: 1 in flight + 4 buffered
    do_reset();
    seq6 = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd1, 3'd1};
    acc_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      cmd_valid = 1'b1; cmd = seq6[i];
      if (cmd_ready) acc_cnt++;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
    end
    chk("bp.accepted", acc_cnt, 5);
    @(negedge clk);
    chk("bp.rdy_full", cmd_ready, 0);
    pulse_done();
    @(negedge clk);
    @(negedge clk);
    chk("bp.rdy_after", cmd_ready, 1);
    chk("bp.col", pos_col, 1);

    // Reset during WAIT, then a late exec_done
    do_reset();
    @(negedge clk);
    cmd_valid = 1'b1; cmd = 3'd1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (20) @(negedge clk);
    do_reset();
    @(negedge clk);
    compare_all("rstwait");
    pulse_done();
    @(negedge clk);
    chk("late.err", err, 1);

    // Watchdog behaviour in WAIT
    do_reset();
    @(negedge clk);
    cmd_valid = 1'b1; cmd = 3'd1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!exec_start && n < 10);
    chk("wd.start", exec_start, 1);
`ifdef WATCHDOG_EN
    n = 0;
    do begin @(negedge clk); n++; end while (!err && n < 400);
    chk("wd.cycles", n, 256);
    chk("wd.rdy", cmd_ready, 0);
`else
    repeat (300) @(negedge clk);
    chk("nowd.err", err, 0);
    chk("nowd.busy", busy, 1);
    chk("nowd.rdy", cmd_ready, 1);
`endif

    // Randomized walks against the model
    for (int t = 0; t < 6; t++) begin
      do_reset();
      for (int k = 0; k < 25; k++) begin
        if (m_done) break;
        if ($urandom_range(0, 15) == 0) c = $urandom_range(5, 7);
        else if ($urandom_range(0, 1) == 0) c = 1;
        else c = $urandom_range(1, 4);
        do_move(c);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
